// File: rtl/lstm_gate_preact_mac_pkg.sv
// Shared types and helpers for the LSTM gate pre-activation MAC engine.
// Exports: state_e (controller states), default widths, sat_shift().
package lstm_gate_preact_mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_VEC,
        MAC,
        OUT,
        DONE
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ACC_W  = 72;
    localparam int DEF_FRAC_W = 16;
    localparam int DEF_N_IN   = 100;
    localparam int DEF_N_OUT  = 400;
    localparam int DEF_LANES  = 4;

    // Working width for the shift/clamp; holds any ACC_W < 128.
    localparam int WIDE_W = 128;

    // Arithmetic shift by frac_w, then clamp to a signed data_w range.
    function automatic logic signed [WIDE_W-1:0] sat_shift(
        input logic signed [WIDE_W-1:0] acc,
        input int                       frac_w,
        input int                       data_w
    );
        logic signed [WIDE_W-1:0] sh;
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        sh = acc >>> frac_w;
        hi = $signed((128'd1 << (data_w - 1)) - 128'd1);
        lo = ~hi;
        if (sh > hi) begin
            return hi;
        end
        if (sh < lo) begin
            return lo;
        end
        return sh;
    endfunction

endpackage

// File: rtl/lstm_gate_preact_mac_lane.sv
// One MAC lane: accumulates w*v products (or a bias word scaled by 2^FRAC_W).
// Ports: clk, rst_n, clr, en, bias_sel, a (weight), b (vector) -> res, sat.
module lstm_gate_preact_mac_lane
    import lstm_gate_preact_mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              bias_sel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic              sat
);

    logic [ACC_W-1:0]         acc_q;
    logic [ACC_W-1:0]         acc_d;
    logic [2*DATA_W-1:0]      a_ext;
    logic [2*DATA_W-1:0]      b_ext;
    logic [2*DATA_W-1:0]      prod;
    logic [ACC_W-1:0]         term;
    logic signed [WIDE_W-1:0] acc_wide;
    logic signed [WIDE_W-1:0] shifted;
    logic signed [WIDE_W-1:0] clamped;

    always_comb begin
        // Low 2*DATA_W bits of the product of sign-extended operands
        // equal the exact signed product.
        a_ext = {{DATA_W{a[DATA_W-1]}}, a};
        b_ext = {{DATA_W{b[DATA_W-1]}}, b};
        prod  = a_ext * b_ext;
        if (bias_sel) begin
            term = {{(ACC_W-DATA_W){a[DATA_W-1]}}, a} << FRAC_W;
        end else begin
            term = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + term;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        acc_wide = {{(WIDE_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        shifted  = acc_wide >>> FRAC_W;
        clamped  = sat_shift(acc_wide, FRAC_W, DATA_W);
        res      = clamped[DATA_W-1:0];
        sat      = (clamped != shifted);
    end

endmodule

// File: rtl/lstm_gate_preact_mac.sv
// LSTM gate pre-activation engine: A[j] = Wx*x + Wh*h (+ b), LANES columns per group.
// Ports: start/use_bias/busy/done/sat_flag, vec_* and w_* input streams, out_* result stream.
module lstm_gate_preact_mac
    import lstm_gate_preact_mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int N_IN   = DEF_N_IN,
    parameter int N_OUT  = DEF_N_OUT,
    parameter int LANES  = DEF_LANES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    use_bias,
    output logic                    busy,
    output logic                    done,
    output logic                    sat_flag,
    input  logic                    vec_valid,
    output logic                    vec_ready,
    input  logic [DATA_W-1:0]       vec_data,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [LANES*DATA_W-1:0] w_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [((N_OUT/LANES) > 1 ? $clog2(N_OUT/LANES) : 1)-1:0] out_grp
);

    localparam int N_GRP  = N_OUT / LANES;
    localparam int GRP_W  = (N_GRP > 1) ? $clog2(N_GRP) : 1;
    localparam int VBUF   = 2 * N_IN;
    localparam int VIDX_W = $clog2(VBUF);
    localparam int CNT_W  = VIDX_W + 1;

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [GRP_W-1:0]  grp_q;
    logic [GRP_W-1:0]  grp_d;
    logic              bias_q;
    logic              bias_d;
    logic              sat_q;
    logic              sat_d;
    logic [DATA_W-1:0] vbuf_q [VBUF];
    logic              vbuf_we;
    logic [VIDX_W-1:0] vidx;
    logic              bias_beat;
    logic              last_beat;
    logic              lane_clr;
    logic              lane_en;
    logic [DATA_W-1:0] vec_sel;
    logic [LANES-1:0]  lane_sat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grp_q   <= '0;
            bias_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grp_q   <= grp_d;
            bias_q  <= bias_d;
            sat_q   <= sat_d;
        end
    end

    // Vector buffer is plain storage; contents are rewritten every run.
    always_ff @(posedge clk) begin
        if (vbuf_we) begin
            vbuf_q[vidx] <= vec_data;
        end
    end

    // One counter serves as load index in LOAD_VEC and beat index in MAC.
    always_comb begin
        vidx      = cnt_q[VIDX_W-1:0];
        bias_beat = bias_q && (cnt_q == CNT_W'(VBUF));
        last_beat = bias_q ? bias_beat : (cnt_q == CNT_W'(VBUF - 1));
        vec_sel   = bias_beat ? '0 : vbuf_q[vidx];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grp_d   = grp_q;
        bias_d  = bias_q;
        sat_d   = sat_q;
        vbuf_we = 1'b0;
        lane_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_VEC;
                    cnt_d   = '0;
                    grp_d   = '0;
                    bias_d  = use_bias;
                    sat_d   = 1'b0;
                end
            end
            LOAD_VEC: begin
                if (vec_valid) begin
                    vbuf_we = 1'b1;
                    if (cnt_q == CNT_W'(VBUF - 1)) begin
                        cnt_d   = '0;
                        state_d = MAC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            MAC: begin
                if (w_valid) begin
                    lane_en = 1'b1;
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = OUT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            OUT: begin
                if (|lane_sat) begin
                    sat_d = 1'b1;
                end
                if (out_ready) begin
                    if (grp_q == GRP_W'(N_GRP - 1)) begin
                        grp_d   = '0;
                        state_d = DONE;
                    end else begin
                        grp_d   = grp_q + GRP_W'(1);
                        state_d = MAC;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Accumulators restart on every entry into MAC.
        lane_clr = (state_d == MAC) && (state_q != MAC);
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        vec_ready = (state_q == LOAD_VEC);
        w_ready   = (state_q == MAC);
        out_valid = (state_q == OUT);
        out_grp   = grp_q;
        sat_flag  = sat_q;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lstm_gate_preact_mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (lane_clr),
            .en       (lane_en),
            .bias_sel (bias_beat),
            .a        (w_data[l*DATA_W +: DATA_W]),
            .b        (vec_sel),
            .res      (out_data[l*DATA_W +: DATA_W]),
            .sat      (lane_sat[l])
        );
    end

endmodule
